instruction_fetch: RTL

Instruction fetch unit: the initiator side of the instruction memory read interface. It owns the program counter, drives the word address into the combinational `instruction_memory`, and captures the returned 32-bit word with its PC into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. It supports branch redirect with buffer flush, and stops fetching after a halt instruction.

---
 rtl/instruction_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Initiator side of the instruction memory read path. Owns the program
// counter, presents it as a word address to a combinational instruction
// memory, and captures {instruction, pc} into a 2-entry buffer that feeds
// decode over a valid/ready handshake. A taken branch/jump redirects the PC
// and flushes the buffer. Fetching stops after a HALT_WORD has been buffered
// and resumes only on redirect or reset.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   imem_addr      out  ADDR_W word address to instruction memory (== pc)
//   imem_data      in   DATA_W instruction returned for imem_addr
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   ADDR_W new fetch address, used when redirect_valid=1
//   out_valid      out  buffer head holds a valid instruction
//   out_ready      in   decode accepts the head this cycle
//   out_instr      out  DATA_W head instruction
//   out_pc         out  ADDR_W PC of the head instruction
//   halted         out  fetch stopped on HALT_WORD
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                 ADDR_W    = 16,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  // Fetch FSM encoding
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam int         DEPTH      = 2;
  localparam logic [1:0] COUNT_FULL = 2'd2;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [0:0]        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [1:0]        count_q,  count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic pop;
  logic push;
  logic has_room;
  logic fetch_is_halt;

  assign out_valid     = (count_q != 2'd0);
  assign pop           = out_valid && out_ready;
  // A full buffer can still take a fetch when the head leaves on the same edge.
  assign has_room      = (count_q != COUNT_FULL) || pop;
  assign push          = (state_q == ST_RUN) && !redirect_valid && has_room;
  assign fetch_is_halt = (imem_data == HALT_WORD);

  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_HALT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (redirect_valid) begin
      // Redirect wins over fetch and halt. A same-cycle pop has already been
      // taken by decode; whatever is left in the buffer is stale path.
      state_d  = ST_RUN;
      pc_d     = redirect_pc;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_q + 2'(push) - 2'(pop);

      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end

      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        // Wraps naturally modulo 2^ADDR_W.
        pc_d     = pc_q + ADDR_W'(1);
        // The halt word itself is buffered so decode still observes it.
        if (fetch_is_halt) begin
          state_d = ST_HALT;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage. Contents are only meaningful while counted, so the data
  // registers carry no reset; validity lives entirely in count_q.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic              wr_en;

    assign wr_en = push && (wr_ptr_q == 1'(gi));

    always_ff @(posedge clk) begin
      if (wr_en) begin
        instr_q <= imem_data;
        pc_q    <= imem_addr;
      end
    end
  end

  // Head selection by read pointer.
  assign out_instr = rd_ptr_q ? g_entry[1].instr_q : g_entry[0].instr_q;
  assign out_pc    = rd_ptr_q ? g_entry[1].pc_q    : g_entry[0].pc_q;

endmodule
